// File: rtl/niosii_sysid_checker.sv
// Avalon-MM master that reads the two sysid words and compares them against
// build-time constants, publishing a registered match status and mismatch count.
module niosii_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1490495959,
  parameter int          READ_LATENCY       = 0,
  parameter bit          AUTO_START         = 1'b1,
  parameter int unsigned RECHECK_CYCLES     = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sys_address,
  output logic        sys_read,
  input  logic [31:0] sys_readdata,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        match,
  output logic [7:0]  mismatch_count,
  output logic [31:0] id_q,
  output logic [31:0] ts_q
);

  // state  | meaning
  // IDLE   | waiting for start or the post-reset auto check
  // RD_ID  | reading word 0 (system ID)
  // RD_TS  | reading word 1 (build timestamp)
  // CMP    | comparing captured words, updating flags
  // RWAIT  | counting down to the next automatic re-check
  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CMP, RWAIT} state_t;

  localparam logic [3:0]  LAT   = 4'(READ_LATENCY);
  localparam logic [31:0] RECHK = 32'(RECHECK_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic [31:0] wait_q, wait_d;
  logic        auto_q, auto_d;
  logic        sys_address_q, sys_address_d;
  logic        sys_read_q, sys_read_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        valid_q, valid_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        match_q, match_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] id_word_q, id_word_d;
  logic [31:0] ts_word_q, ts_word_d;

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    wait_d    = wait_q;
    auto_d    = 1'b0;
    done_d    = 1'b0;
    valid_d   = valid_q;
    id_ok_d   = id_ok_q;
    ts_ok_d   = ts_ok_q;
    match_d   = match_q;
    cnt_d     = cnt_q;
    id_word_d = id_word_q;
    ts_word_d = ts_word_q;
    case (state_q)
      IDLE: begin
        if (start || auto_q) begin
          state_d = RD_ID;
          lat_d   = 4'd0;
        end
      end
      RD_ID: begin
        if (lat_q == LAT) begin
          id_word_d = sys_readdata;
          state_d   = RD_TS;
          lat_d     = 4'd0;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      RD_TS: begin
        if (lat_q == LAT) begin
          ts_word_d = sys_readdata;
          state_d   = CMP;
          lat_d     = 4'd0;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      CMP: begin
        id_ok_d = (id_word_q == EXPECTED_ID);
        ts_ok_d = (ts_word_q == EXPECTED_TIMESTAMP);
        match_d = id_ok_d && ts_ok_d;
        valid_d = 1'b1;
        done_d  = 1'b1;
        if (!match_d && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
        // Loading N-1 and leaving at zero gives exactly N cycles in RWAIT.
        if (RECHK != 32'd0) begin
          state_d = RWAIT;
          wait_d  = RECHK - 32'd1;
        end else begin
          state_d = IDLE;
        end
      end
      RWAIT: begin
        if (start || (wait_q == 32'd0)) begin
          state_d = RD_ID;
          lat_d   = 4'd0;
        end else begin
          wait_d = wait_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Bus strobes and busy follow the next state so they are glitch-free flops.
    sys_address_d = (state_d == RD_TS);
    sys_read_d    = (state_d == RD_ID) || (state_d == RD_TS);
    busy_d        = sys_read_d || (state_d == CMP);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      lat_q         <= 4'd0;
      wait_q        <= 32'd0;
      auto_q        <= AUTO_START;
      sys_address_q <= 1'b0;
      sys_read_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      valid_q       <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      match_q       <= 1'b0;
      cnt_q         <= 8'd0;
      id_word_q     <= 32'd0;
      ts_word_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      lat_q         <= lat_d;
      wait_q        <= wait_d;
      auto_q        <= auto_d;
      sys_address_q <= sys_address_d;
      sys_read_q    <= sys_read_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      valid_q       <= valid_d;
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      match_q       <= match_d;
      cnt_q         <= cnt_d;
      id_word_q     <= id_word_d;
      ts_word_q     <= ts_word_d;
    end
  end

  assign sys_address    = sys_address_q;
  assign sys_read       = sys_read_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign valid          = valid_q;
  assign id_ok          = id_ok_q;
  assign ts_ok          = ts_ok_q;
  assign match          = match_q;
  assign mismatch_count = cnt_q;
  assign id_q           = id_word_q;
  assign ts_q           = ts_word_q;

endmodule

// File: tb/tb_niosii_sysid_checker.sv
// Bench for niosii_sysid_checker: four instances covering zero latency, latency 3,
// latency mismatch against a slow slave, and periodic re-check with saturation.
module tb_niosii_sysid_checker;

  localparam logic [31:0] TS_OK  = 32'd1490495959;
  localparam logic [31:0] TS_BAD = 32'd1490495958;
  localparam logic [31:0] ID_B   = 32'h1234_ABCD;

  typedef struct packed {
    logic        id_ok;
    logic        ts_ok;
    logic        match;
    logic [7:0]  cnt;
    logic [31:0] id;
    logic [31:0] ts;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  // Instance A: L=0, combinational slave with adjustable words
  logic [31:0] a_id_word = 32'd0, a_ts_word = TS_OK, a_rdata;
  logic a_addr, a_read, a_busy, a_done, a_valid, a_id_ok, a_ts_ok, a_match;
  logic [7:0] a_cnt;
  logic [31:0] a_id_q, a_ts_q;
  assign a_rdata = a_addr ? a_ts_word : a_id_word;

  niosii_sysid_checker u_a (
    .clock(clock), .reset(reset), .start(start_a),
    .sys_address(a_addr), .sys_read(a_read), .sys_readdata(a_rdata),
    .busy(a_busy), .done(a_done), .valid(a_valid), .id_ok(a_id_ok), .ts_ok(a_ts_ok),
    .match(a_match), .mismatch_count(a_cnt), .id_q(a_id_q), .ts_q(a_ts_q));

  // Instance B: L=3 against a slave whose data trails the address by 3 cycles
  logic [2:0] b_dl;
  logic [31:0] b_rdata;
  logic b_addr, b_read, b_busy, b_done, b_valid, b_id_ok, b_ts_ok, b_match;
  logic [7:0] b_cnt;
  logic [31:0] b_id_q, b_ts_q;
  always @(posedge clock or posedge reset)
    if (reset) b_dl <= 3'd0; else b_dl <= {b_dl[1:0], b_addr};
  assign b_rdata = b_dl[2] ? TS_OK : ID_B;

  niosii_sysid_checker #(.EXPECTED_ID(ID_B), .READ_LATENCY(3)) u_b (
    .clock(clock), .reset(reset), .start(1'b0),
    .sys_address(b_addr), .sys_read(b_read), .sys_readdata(b_rdata),
    .busy(b_busy), .done(b_done), .valid(b_valid), .id_ok(b_id_ok), .ts_ok(b_ts_ok),
    .match(b_match), .mismatch_count(b_cnt), .id_q(b_id_q), .ts_q(b_ts_q));

  // Instance C: L=0 against the same slow slave type -> timestamp reads stale ID
  logic [2:0] c_dl;
  logic [31:0] c_rdata;
  logic c_addr, c_read, c_busy, c_done, c_valid, c_id_ok, c_ts_ok, c_match;
  logic [7:0] c_cnt;
  logic [31:0] c_id_q, c_ts_q;
  always @(posedge clock or posedge reset)
    if (reset) c_dl <= 3'd0; else c_dl <= {c_dl[1:0], c_addr};
  assign c_rdata = c_dl[2] ? TS_OK : ID_B;

  niosii_sysid_checker #(.EXPECTED_ID(ID_B), .READ_LATENCY(0)) u_c (
    .clock(clock), .reset(reset), .start(1'b0),
    .sys_address(c_addr), .sys_read(c_read), .sys_readdata(c_rdata),
    .busy(c_busy), .done(c_done), .valid(c_valid), .id_ok(c_id_ok), .ts_ok(c_ts_ok),
    .match(c_match), .mismatch_count(c_cnt), .id_q(c_id_q), .ts_q(c_ts_q));

  // Instance D: RECHECK_CYCLES=2, slave always returns a wrong ID
  logic [31:0] d_rdata;
  logic d_addr, d_read, d_busy, d_done, d_valid, d_id_ok, d_ts_ok, d_match;
  logic [7:0] d_cnt;
  logic [31:0] d_id_q, d_ts_q;
  assign d_rdata = d_addr ? TS_OK : 32'hFFFF_FFFF;

  niosii_sysid_checker #(.RECHECK_CYCLES(2)) u_d (
    .clock(clock), .reset(reset), .start(1'b0),
    .sys_address(d_addr), .sys_read(d_read), .sys_readdata(d_rdata),
    .busy(d_busy), .done(d_done), .valid(d_valid), .id_ok(d_id_ok), .ts_ok(d_ts_ok),
    .match(d_match), .mismatch_count(d_cnt), .id_q(d_id_q), .ts_q(d_ts_q));

  int a_dones = 0;
  int d_dones = 0;
  always @(posedge clock) begin
    if (a_done) a_dones <= a_dones + 1;
    if (d_done) d_dones <= d_dones + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_ctl"}, {24'd0, a_addr, a_read, a_busy, a_done, a_valid, a_id_ok, a_ts_ok, a_match}, 32'd0);
    check({tag, "_cnt"}, {24'd0, a_cnt}, 32'd0);
    check({tag, "_id_q"}, a_id_q, 32'd0);
    check({tag, "_ts_q"}, a_ts_q, 32'd0);
  endtask

  task automatic sb_compare_a(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, {31'd0, (sb.size() > 0)}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_id_ok"}, {31'd0, a_id_ok}, {31'd0, e.id_ok});
      check({tag, "_ts_ok"}, {31'd0, a_ts_ok}, {31'd0, e.ts_ok});
      check({tag, "_match"}, {31'd0, a_match}, {31'd0, e.match});
      check({tag, "_valid"}, {31'd0, a_valid}, 32'd1);
      check({tag, "_cnt"}, {24'd0, a_cnt}, {24'd0, e.cnt});
      check({tag, "_id_q"}, a_id_q, e.id);
      check({tag, "_ts_q"}, a_ts_q, e.ts);
    end
  endtask

  task automatic wait_done_a(input string tag);
    int k = 0;
    while (!a_done && k < 100) begin
      @(negedge clock);
      k++;
    end
    check({tag, "_done_seen"}, {31'd0, a_done}, 32'd1);
  endtask

  initial begin
    int base;
    int k;

    // Reset state
    @(negedge clock);
    check_a_zero("reset");
    check("reset_b_ctl", {26'd0, b_addr, b_read, b_busy, b_done, b_valid, b_match}, 32'd0);

    // Auto-start after release: cycle-accurate timing for A (L=0), B (L=3), D (re-check)
    sb.push_back('{id_ok: 1'b1, ts_ok: 1'b1, match: 1'b1, cnt: 8'd0, id: 32'd0, ts: TS_OK});
    reset = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      @(negedge clock);
      check($sformatf("a_busy_n%0d", n), {31'd0, a_busy}, {31'd0, n <= 2});
      check($sformatf("a_done_n%0d", n), {31'd0, a_done}, {31'd0, n == 3});
      check($sformatf("a_read_n%0d", n), {31'd0, a_read}, {31'd0, n <= 1});
      check($sformatf("a_addr_n%0d", n), {31'd0, a_addr}, {31'd0, n == 1});
      check($sformatf("b_busy_n%0d", n), {31'd0, b_busy}, {31'd0, n <= 8});
      check($sformatf("b_done_n%0d", n), {31'd0, b_done}, {31'd0, n == 9});
      check($sformatf("b_read_n%0d", n), {31'd0, b_read}, {31'd0, n <= 7});
      check($sformatf("b_addr_n%0d", n), {31'd0, b_addr}, {31'd0, n >= 4 && n <= 7});
      check($sformatf("d_busy_n%0d", n), {31'd0, d_busy}, {31'd0, (n % 5) <= 2});
      check($sformatf("d_done_n%0d", n), {31'd0, d_done}, {31'd0, n >= 3 && (n % 5) == 3});
      if (n == 3) begin
        sb_compare_a("auto");
        check("c_id_ok", {31'd0, c_id_ok}, 32'd1);
        check("c_ts_ok", {31'd0, c_ts_ok}, 32'd0);
        check("c_match", {31'd0, c_match}, 32'd0);
        check("c_cnt", {24'd0, c_cnt}, 32'd1);
      end
      if (n == 9) begin
        check("b_match", {31'd0, b_match}, 32'd1);
        check("b_id_q", b_id_q, ID_B);
        check("b_ts_q", b_ts_q, TS_OK);
        check("b_cnt", {24'd0, b_cnt}, 32'd0);
      end
    end

    // Wrong timestamp, single start pulse in IDLE
    a_ts_word = TS_BAD;
    sb.push_back('{id_ok: 1'b1, ts_ok: 1'b0, match: 1'b0, cnt: 8'd1, id: 32'd0, ts: TS_BAD});
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    wait_done_a("badts");
    sb_compare_a("badts");

    // start held during the whole busy window: exactly one check
    a_ts_word = TS_OK;
    repeat (2) @(negedge clock);
    base = a_dones;
    sb.push_back('{id_ok: 1'b1, ts_ok: 1'b1, match: 1'b1, cnt: 8'd1, id: 32'd0, ts: TS_OK});
    start_a = 1'b1;
    @(negedge clock);
    k = 0;
    while (a_busy && k < 50) begin
      @(negedge clock);
      k++;
    end
    start_a = 1'b0;
    check("hold_done_at_busy_fall", {31'd0, a_done}, 32'd1);
    sb_compare_a("hold");
    repeat (6) @(negedge clock);
    check("hold_single_done", a_dones - base, 32'd1);
    check("hold_idle_after", {31'd0, a_busy}, 32'd0);

    // Periodic re-check on D saturates the mismatch counter
    repeat (1500) @(negedge clock);
    check("d_cnt_saturated", {24'd0, d_cnt}, 32'd255);
    check("d_many_checks", {31'd0, d_dones >= 300}, 32'd1);
    check("d_valid", {31'd0, d_valid}, 32'd1);

    // Reset during RD_TS aborts, then auto-start reruns a fresh check
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    @(negedge clock);
    check("abort_in_rd_ts", {30'd0, a_addr, a_read}, 32'd3);
    base = a_dones;
    reset = 1'b1;
    #1;
    check_a_zero("abort");
    sb.push_back('{id_ok: 1'b1, ts_ok: 1'b1, match: 1'b1, cnt: 8'd0, id: 32'd0, ts: TS_OK});
    @(negedge clock);
    reset = 1'b0;
    wait_done_a("rerun");
    sb_compare_a("rerun");
    repeat (4) @(negedge clock);
    check("rerun_single_done", a_dones - base, 32'd1);
    check("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
